disp_scan_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between up to N_REQ requesters, for example the sell/quantity view, the add/restock view and the sales-total view. The block arbitrates requesters round-robin at frame boundaries and enforces minimum and maximum hold times. It generates the digit-scan timing and BCD-to-segment decode, with a blanking slot on every ownership change. It sits between the mode logic and the board's DIG/segment pins.

---
 rtl/disp_scan_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_disp_scan_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter: round-robin owner of the 8-digit seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module disp_scan_arbiter #(
    parameter int N_REQ      = 3,
    parameter int SCAN_DIV   = 100000,
    parameter int MIN_FRAMES = 2,
    parameter int MAX_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*32-1:0] frame_i,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [7:0]         dig_sel,
    output logic [7:0]         seg_out
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_REQ > 2) ? 2 : 1;
    localparam int FW = $clog2(MAX_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [FW:0]   MINF    = (FW+1)'(MIN_FRAMES);
    localparam logic [FW:0]   MAXF    = (FW+1)'(MAX_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_BLANK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        slot_q, slot_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     own_q, own_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [7:0]        dig_q, dig_d;
    logic [7:0]        seg_q, seg_d;

    logic              tick;
    logic              take;
    logic [IW-1:0]     win;
    logic [31:0]       fr_win;
    logic [31:0]       fr_own;
    logic [FW:0]       f;
    logic [2:0]        slot_n;

    function automatic logic [7:0] seg_dec(input logic [3:0] c);
        logic [7:0] s;
        case (c)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            4'd15:   s = 8'h40;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] digit_seg(input logic [31:0] fr,
                                             input logic [2:0]  d);
        logic [3:0] c;
        logic [7:0] s;
        c = fr[{d, 2'b00} +: 4];
        s = seg_dec(c);
`ifdef LEADING_ZERO_BLANK_EN
        begin : lzb
            logic       hz;
            logic [3:0] n;
            hz = 1'b1;
            for (int i = 1; i < 8; i++) begin
                n = fr[i*4 +: 4];
                if (i > int'(d) &&
                    !(n == 4'd0 || (n >= 4'd10 && n <= 4'd14)))
                    hz = 1'b0;
            end
            if (d != 3'd0 && c == 4'd0 && hz)
                s = 8'h00;
        end
`endif
        return s;
    endfunction

    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    p);
        logic [IW-1:0] w;
        logic          found;
        int            k;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(p) + i) % N_REQ;
            if (!found && r[k]) begin
                w     = IW'(k);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign tick    = (cnt_q == CNT_MAX);
    assign grant   = grant_q;
    assign dig_sel = dig_q;
    assign seg_out = seg_q;
    assign busy    = (state_q != S_IDLE);

    // Next-state: prescaler, scan slot, arbitration and registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        slot_d  = slot_q;
        fcnt_d  = fcnt_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        grant_d = grant_q;
        dig_d   = dig_q;
        seg_d   = seg_q;
        take    = 1'b0;
        slot_n  = slot_q + 3'd1;
        f       = {1'b0, fcnt_q} + 1'b1;
        win     = rr_pick(req, ptr_q);
        fr_win  = frame_i[int'(win)*32 +: 32];
        fr_own  = frame_i[int'(own_q)*32 +: 32];
        case (state_q)
            S_IDLE: begin
                if (tick && req != '0)
                    take = 1'b1;
            end
            S_ACTIVE: begin
                if (tick) begin
                    if (slot_q == 3'd7) begin
                        if ((!req[own_q] && f >= MINF) ||
                            (f >= MAXF && (req & ~grant_q) != '0)) begin
                            state_d = S_BLANK;
                            grant_d = '0;
                            dig_d   = 8'h00;
                            seg_d   = 8'h00;
                            slot_d  = 3'd0;
                        end else begin
                            slot_d = 3'd0;
                            fcnt_d = (f >= MAXF) ? MAXF[FW-1:0] : f[FW-1:0];
                            dig_d  = 8'h01;
                            seg_d  = digit_seg(fr_own, 3'd0);
                        end
                    end else begin
                        slot_d = slot_n;
                        dig_d  = 8'h01 << slot_n;
                        seg_d  = digit_seg(fr_own, slot_n);
                    end
                end
            end
            S_BLANK: begin
                if (tick) begin
                    if (req != '0)
                        take = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            state_d = S_ACTIVE;
            grant_d = N_REQ'(1) << win;
            own_d   = win;
            ptr_d   = IW'((int'(win) + 1) % N_REQ);
            slot_d  = 3'd0;
            fcnt_d  = '0;
            dig_d   = 8'h01;
            seg_d   = digit_seg(fr_win, 3'd0);
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            fcnt_q  <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            grant_q <= '0;
            dig_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            fcnt_q  <= fcnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// tb_disp_scan_arbiter: directed scoreboard bench for disp_scan_arbiter.
// Expected per-slot outputs are queued, then compared at each scan slot.
module tb_disp_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [31:0] fr0 = '0;
    logic [31:0] fr1 = '0;
    logic [31:0] fr2 = '0;
    logic [95:0] frame_i;
    logic [2:0]  grant;
    logic        busy;
    logic [7:0]  dig_sel;
    logic [7:0]  seg_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] g;
        logic       b;
        logic [7:0] d;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];

    logic [1:0] ph;

    assign frame_i = {fr2, fr1, fr0};

    disp_scan_arbiter #(
        .N_REQ(3),
        .SCAN_DIV(4),
        .MIN_FRAMES(2),
        .MAX_FRAMES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .frame_i(frame_i),
        .grant(grant),
        .busy(busy),
        .dig_sel(dig_sel),
        .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    // Independent slot phase: outputs update where this wraps to 0
    always @(posedge clk or negedge rst)
        if (!rst) ph <= 2'd0;
        else      ph <= ph + 2'd1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dec(input logic [3:0] c);
        case (c)
            4'd0: return 8'h3F;  4'd1: return 8'h06;
            4'd2: return 8'h5B;  4'd3: return 8'h4F;
            4'd4: return 8'h66;  4'd5: return 8'h6D;
            4'd6: return 8'h7D;  4'd7: return 8'h07;
            4'd8: return 8'h7F;  4'd9: return 8'h6F;
            4'd15: return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic b,
                        input logic [7:0] d, input logic [7:0] s);
        exp_t e;
        e.g = g; e.b = b; e.d = d; e.s = s;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [2:0] g, input logic [31:0] fr,
                              input int n);
        logic [31:0] t;
        t = fr;
        for (int d = 0; d < n; d++)
            push(g, 1'b1, 8'h01 << d, dec(t[d*4 +: 4]));
    endtask

    task automatic wait_slot();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ph == 2'd0) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL slot_align observed=none expected=slot edge");
        end
    endtask

    task automatic check_slots(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            wait_slot();
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s observed=empty expected=entry", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_grant"}, {5'd0, grant}, {5'd0, e.g});
                chk({tag, "_busy"}, {7'd0, busy}, {7'd0, e.b});
                chk({tag, "_dig"}, dig_sel, e.d);
                chk({tag, "_seg"}, seg_out, e.s);
            end
        end
    endtask

    initial begin
        // Reset held with all requests up
        req = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", {5'd0, grant}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_dig", dig_sel, 8'h00);
        chk("rst_seg", seg_out, 8'h00);
        req = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            chk("idle_grant", {5'd0, grant}, 8'h00);
            chk("idle_dig", dig_sel, 8'h00);
        end

        // Single requester 0, drops after one frame
        wait_slot();
        fr0 = 32'h12345678;
        req = 3'b001;
        push_frame(3'b001, fr0, 8);
        push_frame(3'b001, fr0, 8);
        push(3'b000, 1'b1, 8'h00, 8'h00);
        push(3'b000, 1'b0, 8'h00, 8'h00);
        check_slots("r0_f1", 8);
        req = 3'b000;
        check_slots("r0_f2", 10);

        // Requester 1 keeps display until MIN frame end
        fr1 = 32'h87654321;
        req = 3'b010;
        push_frame(3'b010, fr1, 8);
        push_frame(3'b010, fr1, 8);
        push(3'b000, 1'b1, 8'h00, 8'h00);
        push(3'b000, 1'b0, 8'h00, 8'h00);
        check_slots("r1_f1", 8);
        req = 3'b000;
        check_slots("r1_f2", 10);

        // Dash and blank codes, then asynchronous reset mid-frame
        fr0 = 32'h1F2C3456;
        req = 3'b001;
        push_frame(3'b001, fr0, 7);
        check_slots("codes", 7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_grant", {5'd0, grant}, 8'h00);
        chk("arst_busy", {7'd0, busy}, 8'h00);
        chk("arst_dig", dig_sel, 8'h00);
        chk("arst_seg", seg_out, 8'h00);

        // Two requesters from reset: MAX hold, blank, round-robin
        fr0 = 32'h12345678;
        fr2 = 32'h00000305;
        req = 3'b101;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++)
            push_frame(3'b001, fr0, 8);
        push(3'b000, 1'b1, 8'h00, 8'h00);
        push(3'b100, 1'b1, 8'h01, 8'h6D);
        push(3'b100, 1'b1, 8'h02, 8'h3F);
        push(3'b100, 1'b1, 8'h04, 8'h4F);
        for (int d = 3; d < 8; d++)
`ifdef LEADING_ZERO_BLANK_EN
            push(3'b100, 1'b1, 8'h01 << d, 8'h00);
`else
            push(3'b100, 1'b1, 8'h01 << d, 8'h3F);
`endif
        check_slots("rr", 41);
        fr2 = 32'h00000000;
        push(3'b100, 1'b1, 8'h01, 8'h3F);
        for (int d = 1; d < 8; d++)
`ifdef LEADING_ZERO_BLANK_EN
            push(3'b100, 1'b1, 8'h01 << d, 8'h00);
`else
            push(3'b100, 1'b1, 8'h01 << d, 8'h3F);
`endif
        check_slots("zero", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
